// File: rtl/pwm_pkg.sv
// Shared types and saturating arithmetic for the multi-channel PWM block.
// Pure package: no logic, no latency, no flow control.
// Callers cast the int results back to their own duty width.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // Result clamps at limit instead of overflowing past it.
    function automatic int sat_inc(input int val, input int step, input int limit);
        return (val + step > limit) ? limit : val + step;
    endfunction

    // Result clamps at limit instead of wrapping below it.
    function automatic int sat_dec(input int val, input int step, input int limit);
        return (val < limit + step) ? limit : val - step;
    endfunction

endpackage

// File: rtl/pwm_multi_ch_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, tick-sampled s1/s2 stages, rising-edge press pulse.
// Latency: 2 sync cycles plus up to 2 ticks; press is a combinational single-cycle pulse.
// No backpressure; all state holds while ena is low.
module btn_debounce (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn,
    input  logic tick,
    output logic press
);

    logic sync0;
    logic sync1;
    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            s1    <= 1'b0;
            s2    <= 1'b0;
        end else if (ena) begin
            sync0 <= btn;
            sync1 <= sync0;
            // Sampling only on tick filters bounces shorter than a tick period.
            if (tick) begin
                s1 <= sync1;
                s2 <= s1;
            end
        end
    end

    assign press = tick & s1 & ~s2;

endmodule

// File: rtl/pwm_multi_ch.sv
// NUM_CH-channel PWM with a shared period counter and button-driven, shadowed duty control.
// Latency: pwm_out registered one cycle after the compare; duty changes apply at the next period start.
// No backpressure; ena low freezes all state and forces outputs low. PWM_CENTER_EN enables center-aligned mode.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 8,
    parameter int PERIOD    = 10,
    parameter int DUTY_INIT = 5,
    parameter int STEP      = 1,
    parameter int DEB_DIV   = 2,
    localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic [SEL_W-1:0]  ch_sel,
    input  logic              center,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [CNT_W-1:0]  duty_sel,
    output logic              period_start
);

    localparam int DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] INIT = CNT_W'(DUTY_INIT);

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic              press_inc;
    logic              press_dec;
    logic [CNT_W-1:0]  cnt;
    logic              dir_up;
    logic              boundary;
    logic [CNT_W-1:0]  shadow [NUM_CH];
    logic [CNT_W-1:0]  active [NUM_CH];
    logic [NUM_CH-1:0] cmp;
    logic [NUM_CH-1:0] pwm_q;

    // Shared debounce sample tick, frozen together with everything else by ena.
    assign tick = ena & (div_cnt == DIV_W'(DEB_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (ena) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    btn_debounce u_deb_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .btn   (btn_inc),
        .tick  (tick),
        .press (press_inc)
    );

    btn_debounce u_deb_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .btn   (btn_dec),
        .tick  (tick),
        .press (press_dec)
    );

    assign boundary = (cnt == '0) & dir_up;

`ifdef PWM_CENTER_EN
    pwm_mode_e mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            dir_up <= 1'b1;
            mode   <= PWM_EDGE;
        end else if (ena) begin
            if (boundary) begin
                mode <= center ? PWM_CENTER : PWM_EDGE;
            end
            // The end points repeat once in center mode: the turn-around cycle holds cnt.
            if (dir_up) begin
                if (cnt == LAST) begin
                    if (mode == PWM_CENTER) begin
                        dir_up <= 1'b0;
                    end else begin
                        cnt <= '0;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                if (cnt == '0) begin
                    dir_up <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
`else
    logic center_unused;

    assign center_unused = center;
    assign dir_up        = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ena) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= INIT;
                active[i] <= INIT;
            end
        end else if (ena) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (boundary) begin
                    active[i] <= shadow[i];
                end
                if (ch_sel == SEL_W'(i)) begin
                    if (press_inc && !press_dec) begin
                        shadow[i] <= CNT_W'(sat_inc(int'(shadow[i]), STEP, PERIOD));
                    end else if (press_dec && !press_inc) begin
                        shadow[i] <= CNT_W'(sat_dec(int'(shadow[i]), STEP, 0));
                    end
                end
            end
        end
    end

    // On the boundary cycle compare against the duty being loaded, so the new
    // period is clean from its very first count.
    always_comb begin
        cmp = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cmp[i] = cnt < (boundary ? shadow[i] : active[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= '0;
        end else if (ena) begin
            pwm_q <= cmp;
        end
    end

    assign pwm_out      = ena ? pwm_q : '0;
    assign period_start = ena & rst_n & boundary;

    always_comb begin
        duty_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                duty_sel = shadow[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch at default parameters: scoreboarded duty and per-period high-time checks.
module tb_pwm_multi_ch;

    localparam int NCH = 4;
    localparam int PER = 10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ena;
    logic           btn_inc;
    logic           btn_dec;
    logic [1:0]     ch_sel;
    logic           center;
    logic [NCH-1:0] pwm_out;
    logic [7:0]     duty_sel;
    logic           period_start;

    int n_checks = 0;
    int n_errors = 0;
    int model [NCH];
    int exp_duty_q [$];
    int exp_hi_q [$];

    pwm_multi_ch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .btn_inc      (btn_inc),
        .btn_dec      (btn_dec),
        .ch_sel       (ch_sel),
        .center       (center),
        .pwm_out      (pwm_out),
        .duty_sel     (duty_sel),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) model[c] = 5;
    endtask

    task automatic wait_boundary(input string name);
        int n = 0;
        while (period_start !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        n_checks++;
        if (period_start !== 1'b1) begin
            n_errors++;
            $display("FAIL %s boundary: got period_start=%b, required 1 within 100 cycles", name, period_start);
        end
    endtask

    // Measures one full period starting at the next boundary; scale=2 for center mode.
    task automatic check_period(input int len, input int scale, input string name);
        int hi [NCH];
        bit ps_ok = 1'b1;
        for (int c = 0; c < NCH; c++) exp_hi_q.push_back(model[c] * scale);
        wait_boundary(name);
        for (int c = 0; c < NCH; c++) hi[c] = 0;
        for (int k = 1; k <= len; k++) begin
            step();
            for (int c = 0; c < NCH; c++) hi[c] += int'(pwm_out[c]);
            if ((k == len) != (period_start === 1'b1)) ps_ok = 1'b0;
        end
        n_checks++;
        if (!ps_ok) begin
            n_errors++;
            $display("FAIL %s period_start spacing: got irregular pulses, required one every %0d cycles", name, len);
        end
        for (int c = 0; c < NCH; c++) begin
            int e = exp_hi_q.pop_front();
            n_checks++;
            if (hi[c] !== e) begin
                n_errors++;
                $display("FAIL %s ch%0d high time: got %0d, required %0d of %0d", name, c, hi[c], e, len);
            end
        end
    endtask

    task automatic press(input bit inc, input int ch);
        ch_sel = 2'(ch);
        if (inc) begin
            btn_inc = 1'b1;
            model[ch] = (model[ch] + 1 > PER) ? PER : model[ch] + 1;
        end else begin
            btn_dec = 1'b1;
            model[ch] = (model[ch] < 1) ? 0 : model[ch] - 1;
        end
        exp_duty_q.push_back(model[ch]);
        repeat (8) step();
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        repeat (8) step();
        begin
            int e = exp_duty_q.pop_front();
            n_checks++;
            if (duty_sel !== 8'(e)) begin
                n_errors++;
                $display("FAIL press ch%0d duty_sel: got %0d, required %0d", ch, duty_sel, e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0;
        ch_sel = 2'd0; center = 1'b0;
        model_reset();
        repeat (3) step();
        n_checks++;
        if (pwm_out !== 4'b0000 || period_start !== 1'b0) begin
            n_errors++;
            $display("FAIL reset outputs: got pwm_out=%b period_start=%b, required 0000 0", pwm_out, period_start);
        end
        n_checks++;
        if (duty_sel !== 8'd5) begin
            n_errors++;
            $display("FAIL reset duty_sel: got %0d, required 5", duty_sel);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (period_start !== 1'b1) begin
            n_errors++;
            $display("FAIL reset first period_start: got %b, required 1", period_start);
        end
    endtask

    task automatic test_edge_default();
        for (int p = 0; p < 4; p++) check_period(PER, 1, "edge_default");
        for (int c = 0; c < NCH; c++) begin
            ch_sel = 2'(c);
            #1;
            n_checks++;
            if (duty_sel !== 8'd5) begin
                n_errors++;
                $display("FAIL default duty_sel ch%0d: got %0d, required 5", c, duty_sel);
            end
        end
    endtask

    task automatic test_inc();
        for (int i = 0; i < 3; i++) press(1'b1, 2);
        check_period(PER, 1, "inc_ch2");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 7; i++) press(1'b0, 1);
        check_period(PER, 1, "sat_low_ch1");
        for (int i = 0; i < 12; i++) press(1'b1, 1);
        check_period(PER, 1, "sat_high_ch1");
    endtask

    task automatic test_mid_period();
        int hi0 = 0;
        int chg_k = 0;
        int old_duty;
        ch_sel = 2'd0;
        wait_boundary("mid");
        old_duty = model[0];
        for (int k = 1; k <= PER; k++) begin
            if (k == 4) begin
                btn_dec = 1'b1;
                model[0] = (model[0] < 1) ? 0 : model[0] - 1;
                exp_duty_q.push_back(model[0]);
            end
            step();
            hi0 += int'(pwm_out[0]);
            if (chg_k == 0 && duty_sel !== 8'(old_duty)) chg_k = k;
        end
        btn_dec = 1'b0;
        begin
            int e = exp_duty_q.pop_front();
            n_checks++;
            if (chg_k < 4 || chg_k > 9 || duty_sel !== 8'(e)) begin
                n_errors++;
                $display("FAIL mid duty_sel: got %0d at step %0d, required %0d within the period", duty_sel, chg_k, e);
            end
        end
        n_checks++;
        if (hi0 !== old_duty) begin
            n_errors++;
            $display("FAIL mid ch0 same-period high time: got %0d, required %0d", hi0, old_duty);
        end
        repeat (8) step();
        check_period(PER, 1, "mid_next");
    endtask

`ifdef PWM_CENTER_EN
    task automatic test_center();
        press(1'b0, 3);
        press(1'b0, 3);
        center = 1'b1;
        check_period(2 * PER, 2, "center");
        center = 1'b0;
        check_period(PER, 1, "center_back_to_edge");
    endtask
`endif

    task automatic test_ena();
        int n = 0;
        bit zero_ok = 1'b1;
        wait_boundary("ena");
        repeat (4) step();
        ena = 1'b0;
        #1;
        for (int k = 0; k < 15; k++) begin
            if (pwm_out !== 4'b0000 || period_start !== 1'b0) zero_ok = 1'b0;
            step();
        end
        n_checks++;
        if (!zero_ok) begin
            n_errors++;
            $display("FAIL ena low outputs: got pwm_out=%b period_start=%b, required 0000 0", pwm_out, period_start);
        end
        ena = 1'b1;
        while (period_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_checks++;
        if (n !== 6) begin
            n_errors++;
            $display("FAIL ena resume: got boundary after %0d cycles, required 6", n);
        end
        check_period(PER, 1, "ena_after");
    endtask

    task automatic test_reset_mid();
        wait_boundary("rst_mid");
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pwm_out !== 4'b0000 || period_start !== 1'b0) begin
            n_errors++;
            $display("FAIL reset mid outputs: got pwm_out=%b period_start=%b, required 0000 0", pwm_out, period_start);
        end
        step();
        step();
        rst_n = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (period_start !== 1'b1) begin
            n_errors++;
            $display("FAIL reset mid restart: got period_start=%b, required 1", period_start);
        end
        for (int c = 0; c < NCH; c++) begin
            ch_sel = 2'(c);
            #1;
            n_checks++;
            if (duty_sel !== 8'd5) begin
                n_errors++;
                $display("FAIL reset mid duty_sel ch%0d: got %0d, required 5", c, duty_sel);
            end
        end
        check_period(PER, 1, "rst_mid_after");
    endtask

    // Right after reset the sample ticks fall on even edges; a one-cycle
    // glitch latched on an odd edge never reaches s1.
    task automatic test_bounce();
        ch_sel = 2'd0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_reset();
        step();
        step();
        btn_inc = 1'b1;
        step();
        btn_inc = 1'b0;
        repeat (20) step();
        n_checks++;
        if (duty_sel !== 8'd5) begin
            n_errors++;
            $display("FAIL bounce duty_sel: got %0d, required 5", duty_sel);
        end
        check_period(PER, 1, "bounce_after");
    endtask

    initial begin
        test_reset();
        test_edge_default();
        test_inc();
        test_saturate();
        test_mid_period();
`ifdef PWM_CENTER_EN
        test_center();
`endif
        test_ena();
        test_reset_mid();
        test_bounce();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
